// File: rtl/arm_pkg.sv
// Shared types for the ARM-style pipeline: execute/memory payload and NZCV flag layout.
package arm_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned RegW  = 4;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic [DataW-1:0] alu_result;
        logic [DataW-1:0] val_rm;
        logic [RegW-1:0]  dest;
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
    } exe_mem_payload_t;

    function automatic nzcv_t pack_nzcv(input logic n, input logic z, input logic c,
                                        input logic v);
        nzcv_t f;
        f        = '0;
        f[FlagN] = n;
        f[FlagZ] = z;
        f[FlagC] = c;
        f[FlagV] = v;
        return f;
    endfunction

    // Data fields keep their last value; only the side-effecting control bits are dropped.
    function automatic exe_mem_payload_t clear_ctrl(input exe_mem_payload_t p);
        exe_mem_payload_t r;
        r          = p;
        r.wb_en    = 1'b0;
        r.mem_r_en = 1'b0;
        r.mem_w_en = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/status_register.sv
// Architectural NZCV flag register; also read by the decode-stage condition check.
module status_register
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en_i,
    input  logic [3:0]  nzcv_i,
    output logic [3:0]  nzcv_o
);

    nzcv_t nzcv_q;
    nzcv_t nzcv_d;

    always_comb begin
        nzcv_d = nzcv_q;
        if (load_en_i) begin
            nzcv_d = nzcv_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q <= '0;
        end else begin
            nzcv_q <= nzcv_d;
        end
    end

    assign nzcv_o = nzcv_q;

endmodule

// File: rtl/exe_mem_stage.sv
// Execute-to-memory boundary: two-entry skid buffer with a registered in_ready, plus flag commit.
module exe_mem_stage
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              s_bit,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [REG_W-1:0]  dest,
    input  logic              wb_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_val_rm,
    output logic [REG_W-1:0]  out_dest,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [3:0]        status_nzcv,
    output logic [1:0]        occupancy
);

    exe_mem_payload_t main_q, main_d;
    exe_mem_payload_t skid_q, skid_d;
    exe_mem_payload_t in_payload;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q;
    logic             accept;
    logic             dequeue;
    nzcv_t            alu_flags;

    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready_q & ~flush;
    assign dequeue   = out_valid & out_ready;
    assign alu_flags = pack_nzcv(alu_n, alu_z, alu_c, alu_v);

    always_comb begin
        in_payload            = '0;
        in_payload.alu_result = alu_result;
        in_payload.val_rm     = val_rm;
        in_payload.dest       = dest;
        in_payload.wb_en      = wb_en;
        in_payload.mem_r_en   = mem_r_en;
        in_payload.mem_w_en   = mem_w_en;
    end

    // Head always holds the oldest entry; skid is only used while the head is stalled.
    always_comb begin
        main_d  = main_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (accept) begin
                    main_d  = in_payload;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (accept && !dequeue) begin
                    skid_d  = in_payload;
                    count_d = 2'd2;
                end else if (accept) begin
                    main_d  = in_payload;
                end else if (dequeue) begin
                    main_d  = clear_ctrl(main_q);
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (dequeue) begin
                    main_d  = skid_q;
                    skid_d  = clear_ctrl(skid_q);
                    count_d = 2'd1;
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            count_q    <= count_d;
            in_ready_q <= (count_d != 2'd2);
        end
    end

    status_register u_status (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en_i (accept & s_bit),
        .nzcv_i    (alu_flags),
        .nzcv_o    (status_nzcv)
    );

    assign in_ready       = in_ready_q;
    assign occupancy      = count_q;
    assign out_alu_result = main_q.alu_result;
    assign out_val_rm     = main_q.val_rm;
    assign out_dest       = main_q.dest;
    assign out_wb_en      = main_q.wb_en;
    assign out_mem_r_en   = main_q.mem_r_en;
    assign out_mem_w_en   = main_q.mem_w_en;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Bench for exe_mem_stage: directed vector table, reset sequences and random traffic vs a queue model.
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [31:0] alu_result = '0, val_rm = '0;
    logic        alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0, s_bit = 1'b0;
    logic [3:0]  dest = '0;
    logic        wb_en = 1'b0, mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_alu_result, out_val_rm;
    logic [3:0]  out_dest;
    logic        out_wb_en, out_mem_r_en, out_mem_w_en;
    logic [3:0]  status_nzcv;
    logic [1:0]  occupancy;

    exe_mem_stage #(.DATA_W(32), .REG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .s_bit(s_bit), .val_rm(val_rm), .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_val_rm(out_val_rm), .out_dest(out_dest),
        .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
        .status_nzcv(status_nzcv), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rm;
        logic [3:0]  dst;
        logic        wb, mr, mw;
    } ent_t;

    typedef struct {
        logic        iv, fl, ordy, s;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        e_ov;
        logic [31:0] e_head;
        logic [1:0]  e_occ;
        logic        e_ir;
        logic [3:0]  e_nzcv;
    } vec_t;

    ent_t        q[$];
    logic [3:0]  m_flags = 4'b0000;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Payload fields other than alu_result are derived from it so the table stays compact.
    task automatic drive(input logic iv, input logic fl, input logic ordy, input logic s,
                         input logic [31:0] res, input logic [3:0] flg);
        in_valid   = iv;
        flush      = fl;
        out_ready  = ordy;
        s_bit      = s;
        alu_result = res;
        val_rm     = ~res ^ 32'h5a5a_0000;
        dest       = res[7:4] ^ res[3:0];
        wb_en      = res[0];
        mem_r_en   = res[1];
        mem_w_en   = res[2];
        {alu_n, alu_z, alu_c, alu_v} = flg;
    endtask

    task automatic check_model();
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("status_nzcv", 64'(status_nzcv), 64'(m_flags));
        if (q.size() != 0) begin
            chk("out_alu_result", 64'(out_alu_result), 64'(q[0].res));
            chk("out_val_rm", 64'(out_val_rm), 64'(q[0].rm));
            chk("out_dest", 64'(out_dest), 64'(q[0].dst));
            chk("out_ctrl", 64'({out_wb_en, out_mem_r_en, out_mem_w_en}),
                64'({q[0].wb, q[0].mr, q[0].mw}));
        end else begin
            chk("out_ctrl_idle", 64'({out_wb_en, out_mem_r_en, out_mem_w_en}), 64'(0));
        end
    endtask

    // One clock: model consumes the pre-edge inputs, then outputs are sampled 2 ns after the edge.
    task automatic cycle();
        bit   acc, deq;
        ent_t e;
        acc = in_valid && (q.size() < 2) && !flush;
        deq = (q.size() != 0) && out_ready;
        e.res = alu_result; e.rm = val_rm; e.dst = dest;
        e.wb = wb_en; e.mr = mem_r_en; e.mw = mem_w_en;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            if (s_bit) m_flags = {alu_n, alu_z, alu_c, alu_v};
        end
        #2;
        check_model();
    endtask

    function automatic vec_t mk(input logic iv, input logic fl, input logic ordy, input logic s,
                                input logic [31:0] res, input logic [3:0] flg, input logic e_ov,
                                input logic [31:0] e_head, input logic [1:0] e_occ,
                                input logic e_ir, input logic [3:0] e_nzcv);
        vec_t v;
        v.iv = iv; v.fl = fl; v.ordy = ordy; v.s = s; v.res = res; v.flg = flg;
        v.e_ov = e_ov; v.e_head = e_head; v.e_occ = e_occ; v.e_ir = e_ir; v.e_nzcv = e_nzcv;
        return v;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, "_occupancy"}, 64'(occupancy), 64'(0));
        chk({tag, "_nzcv"}, 64'(status_nzcv), 64'(0));
        chk({tag, "_payload"}, 64'(out_alu_result ^ out_val_rm), 64'(0));
        chk({tag, "_ctrl"}, 64'({out_dest, out_wb_en, out_mem_r_en, out_mem_w_en}), 64'(0));
    endtask

    initial begin
        //         iv fl rdy s  res            flg      ov head          occ  ir nzcv
        tbl[0]  = mk(1, 0, 1, 0, 32'h1,        4'h0,    1, 32'h1,        2'd1, 1, 4'h0);
        tbl[1]  = mk(1, 0, 1, 0, 32'h2,        4'h0,    1, 32'h2,        2'd1, 1, 4'h0);
        tbl[2]  = mk(1, 0, 1, 0, 32'h3,        4'h0,    1, 32'h3,        2'd1, 1, 4'h0);
        tbl[3]  = mk(1, 0, 1, 0, 32'h4,        4'h0,    1, 32'h4,        2'd1, 1, 4'h0);
        tbl[4]  = mk(0, 0, 1, 0, 32'h0,        4'h0,    0, 32'h0,        2'd0, 1, 4'h0);
        tbl[5]  = mk(1, 0, 0, 0, 32'hA,        4'h0,    1, 32'hA,        2'd1, 1, 4'h0);
        tbl[6]  = mk(1, 0, 0, 0, 32'hB,        4'h0,    1, 32'hA,        2'd2, 0, 4'h0);
        tbl[7]  = mk(1, 0, 0, 1, 32'hEE,       4'hF,    1, 32'hA,        2'd2, 0, 4'h0);
        tbl[8]  = mk(0, 0, 1, 0, 32'h0,        4'h0,    1, 32'hB,        2'd1, 1, 4'h0);
        tbl[9]  = mk(0, 0, 1, 0, 32'h0,        4'h0,    0, 32'h0,        2'd0, 1, 4'h0);
        tbl[10] = mk(1, 0, 1, 1, 32'h30,       4'b1010, 1, 32'h30,       2'd1, 1, 4'b1010);
        tbl[11] = mk(1, 0, 1, 0, 32'h31,       4'b0101, 1, 32'h31,       2'd1, 1, 4'b1010);
        tbl[12] = mk(0, 0, 1, 0, 32'h0,        4'h0,    0, 32'h0,        2'd0, 1, 4'b1010);
        tbl[13] = mk(1, 0, 0, 0, 32'hC,        4'h0,    1, 32'hC,        2'd1, 1, 4'b1010);
        tbl[14] = mk(1, 1, 0, 1, 32'hDD,       4'b0100, 1, 32'hC,        2'd1, 1, 4'b1010);
        tbl[15] = mk(0, 0, 1, 0, 32'h0,        4'h0,    0, 32'h0,        2'd0, 1, 4'b1010);
        tbl[16] = mk(1, 0, 0, 0, 32'h10,       4'h0,    1, 32'h10,       2'd1, 1, 4'b1010);
        tbl[17] = mk(1, 0, 1, 0, 32'h20,       4'h0,    1, 32'h20,       2'd1, 1, 4'b1010);
        tbl[18] = mk(0, 0, 1, 0, 32'h0,        4'h0,    0, 32'h0,        2'd0, 1, 4'b1010);

        #1 rst_n = 1'b0;
        #2 check_reset_state("por");
        #9 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].iv, tbl[i].fl, tbl[i].ordy, tbl[i].s, tbl[i].res, tbl[i].flg);
            cycle();
            chk($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("row%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].e_occ));
            chk($sformatf("row%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("row%0d_nzcv", i), 64'(status_nzcv), 64'(tbl[i].e_nzcv));
            if (tbl[i].e_ov) begin
                chk($sformatf("row%0d_head", i), 64'(out_alu_result), 64'(tbl[i].e_head));
            end
        end

        // Mid-run asynchronous reset with two entries buffered and flags set.
        drive(1, 0, 0, 1, 32'h77, 4'b1111);
        cycle();
        drive(1, 0, 0, 0, 32'h78, 4'b0000);
        cycle();
        chk("pre_reset_occupancy", 64'(occupancy), 64'(2));
        #1 rst_n = 1'b0;
        #1 check_reset_state("async");
        q.delete();
        m_flags = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 32'h99, 4'h0);
        cycle();
        chk("first_accept_after_reset", 64'(out_alu_result), 64'(32'h99));

        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) > 1, $urandom_range(0, 1) == 1, $urandom,
                  4'($urandom_range(0, 15)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
